sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Single-clock parametrised FIFO, successor to the dual-port FIFO RAM. Adds an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a compile-time first-word-fall-through read mode. Sits between a producer and a consumer in the same clock domain, e.g. as a rate-smoothing buffer in front of a slower datapath stage.

## Interface
- FIFO_WIDTH, 16, data word width in bits
- FIFO_DEPTH, 512, number of storage words; any value ≥ 2, not restricted to powers of 2
- ADDR, 9, pointer width; must satisfy 2**ADDR ≥ FIFO_DEPTH
- AF_LEVEL, 500, almost_full asserts when count ≥ AF_LEVEL; range 1..FIFO_DEPTH
- AE_LEVEL, 8, almost_empty asserts when count ≤ AE_LEVEL; range 0..FIFO_DEPTH-1

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- wen  in  1  write request
- din  in  FIFO_WIDTH  write data
- ren  in  1  read request
- err_clr  in  1  clears overflow and underflow
- dout  out  FIFO_WIDTH  read data
- valid  out  1  dout holds a word; meaning depends on mode (see Configuration)
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  ADDR+1  words currently stored
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Write accepted: wen && !full. Stores din at wr_ptr, then advances wr_ptr.
- Read accepted: ren && !empty. Advances rd_ptr.
- Acceptance uses flags from the current cycle only. When full, a simultaneous read does not free space for the write: the write is rejected. When empty, the write is accepted and the read is rejected.
- count_next = count + write_accepted − read_accepted. Simultaneous accepted read and write leave count unchanged.
- Pointers wrap from FIFO_DEPTH−1 to 0 by explicit compare, not by natural overflow.
- full, empty, almost_full and almost_empty decode combinationally from the registered count and change in the same cycle as count.
- overflow sets on wen && full. underflow sets on ren && empty. Both hold until err_clr or rst.
- If a set condition and err_clr occur in the same cycle, set wins.
- Rejected requests never alter pointers, count or memory.
- rst overrides wen, ren and err_clr in the same cycle and discards stored contents.
- Reset values:
  - pointers 0, count 0
  - empty 1, full 0
  - almost_empty 1, almost_full 0
  - valid 0, dout 0
  - overflow 0, underflow 0
  - memory array is not reset

## Timing
- Write to visibility: a word written at edge N is counted at N (count, empty=0 visible after N). It can be accepted by a read request in the cycle after N.
- Standard mode read latency: 1 cycle. With an accepted ren in the cycle before edge N, dout and valid=1 are registered at N. valid is a 1-cycle pulse per accepted read. dout holds its last value when no read is accepted.
- FWFT mode read latency: 0 cycles. dout = mem[rd_ptr] and valid = !empty continuously. An accepted ren at edge N presents the next word after N.
- Throughput: one write and one read per cycle sustained, as long as count is not 0 or FIFO_DEPTH.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through. The head word is always on dout, valid = !empty, ren acts as a pop/acknowledge, and there is no dout register.
- Undefined: standard registered read as described under Timing. dout is a register and valid is the accepted-read pulse.
- Flags, count, error and acceptance behaviour are identical in both modes.

## Test plan
- Reset then fill: rst for 2 cycles, then 512 writes of din=0..511 with ren=0. Required: almost_full rises when count reaches 500, full=1 and count=512 after the 512th edge, overflow=0.
- Overflow: continuing from full, wen=1, din=16'hDEAD for 1 cycle. Required: overflow=1, count stays 512, a later drain never returns 16'hDEAD. Then err_clr=1 for 1 cycle → overflow=0.
- Drain and order: from full, ren=1 for 512 cycles. Required: dout sequence is 0..511 in order, with 1-cycle latency in standard mode and 0-cycle latency in FWFT mode. almost_empty rises at count=8, empty=1 at the end, underflow=0.
- Underflow plus simultaneous write while empty: ren=1, wen=1, din=16'h00A5 in one cycle. Required: underflow=1, count=1, and the word 16'h00A5 is then readable.
- Wrap-around under concurrent traffic: 300 writes, then 1000 cycles of wen=ren=1 with an incrementing din, then a full drain. Required: count stays 300 throughout the concurrent phase, data order is preserved across the pointer wrap, and no error flag sets.
- Mid-operation reset: at count=37, assert rst for 1 cycle with wen=ren=1. Required: next cycle shows count=0, empty=1, valid=0, dout=0, errors cleared, and the next written word is the first word read.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//
// Single-clock parametrised FIFO. It provides an occupancy count, programmable
// almost-full and almost-empty thresholds, and sticky overflow/underflow error
// flags. The read mode is chosen when the design is compiled.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   defined   : first-word-fall-through. dout always shows the head word,
//               valid = !empty, and ren pops the head word.
//   undefined : registered read. An accepted ren loads the head word into the
//               dout register on the next edge and pulses valid for 1 cycle.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   wen / din     in   write request / write data
//   ren           in   read request
//   err_clr       in   clears overflow and underflow
//   dout / valid  out  read data / read data qualifier
//   full, empty   out  count == FIFO_DEPTH / count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  words currently stored
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
//
// Handshake: a write is accepted on an edge where wen && !full, and a read is
// accepted on an edge where ren && !empty. full and empty are the flags of the
// current cycle. A read accepted in the same cycle does not free space for the
// write. A request that is not accepted changes no pointer, count or memory
// contents. It only sets the matching error flag.
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR       = 9,
  parameter int AF_LEVEL   = 500,
  parameter int AE_LEVEL   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [FIFO_WIDTH-1:0] din,
  input  logic                  ren,
  input  logic                  err_clr,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR:0]   DEPTH_C = (ADDR+1)'(FIFO_DEPTH);
  localparam logic [ADDR:0]   AF_C    = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0]   AE_C    = (ADDR+1)'(AE_LEVEL);
  localparam logic [ADDR-1:0] LAST_C  = ADDR'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
  logic [ADDR-1:0]       r_wr_ptr;
  logic [ADDR-1:0]       r_rd_ptr;
  logic [ADDR:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR-1:0]       w_wr_ptr_nxt;
  logic [ADDR-1:0]       w_rd_ptr_nxt;

  // The flags are decoded from the registered count. They change on the
  // same edge as count.
  assign w_full       = (r_count == DEPTH_C);
  assign w_empty      = (r_count == '0);
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_acc = wen && !w_full;
  assign w_rd_acc = ren && !w_empty;

  // Each pointer wraps by comparing with the last index. This lets
  // FIFO_DEPTH be any value, not only a power of two.
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;

  // The storage array has no reset. The valid words are defined by the
  // pointers and the count.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags. If a set condition and err_clr occur in the same
  // cycle, the flag is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wen && w_full)  r_overflow <= 1'b1;
      else if (err_clr)   r_overflow <= 1'b0;
      if (ren && w_empty) r_underflow <= 1'b1;
      else if (err_clr)   r_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is presented combinationally. While the FIFO is empty,
  // dout is forced to zero, so the uninitialised array is never visible.
  assign dout  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign valid = !w_empty;
`else
  logic [FIFO_WIDTH-1:0] r_dout;
  logic                  r_valid;

  // Registered read. valid pulses once for each accepted read. dout keeps
  // its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
//
// Self-checking bench for sync_fifo_prog with the default parameters. A queue
// model holds the FIFO contents and the expected error flags. After every
// clock edge, all DUT outputs are compared with values derived from that
// model. Stimulus follows the directed scenarios and then runs a randomised
// traffic phase.
// -----------------------------------------------------------------------------
module tb_sync_fifo_prog;

  localparam int W  = 16;
  localparam int D  = 512;
  localparam int A  = 9;
  localparam int AF = 500;
  localparam int AE = 8;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         rst;
  logic         wen;
  logic [W-1:0] din;
  logic         ren;
  logic         err_clr;
  logic [W-1:0] dout;
  logic         valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [A:0]   count;
  logic         overflow;
  logic         underflow;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D), .ADDR(A), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .din(din), .ren(ren), .err_clr(err_clr),
    .dout(dout), .valid(valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  logic         exp_unf;
  logic         exp_valid;
  logic [W-1:0] exp_dout;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check_val("count",        32'(count),        32'(sz));
    check_val("full",         32'(full),         32'(sz == D));
    check_val("empty",        32'(empty),        32'(sz == 0));
    check_val("almost_full",  32'(almost_full),  32'(sz >= AF));
    check_val("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    check_val("overflow",     32'(overflow),     32'(exp_ovf));
    check_val("underflow",    32'(underflow),    32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
    check_val("valid", 32'(valid), 32'(sz != 0));
    if (sz != 0) check_val("dout", 32'(dout), 32'(exp_q[0]));
    else         check_val("dout", 32'(dout), 32'(0));
`else
    check_val("valid", 32'(valid), 32'(exp_valid));
    check_val("dout",  32'(dout),  32'(exp_dout));
`endif
  endtask

  // ---------------------------------------------------------------- driver
  // Inputs are driven on the falling edge. The model is updated on the
  // rising edge, and the outputs are sampled 1 time unit later.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                      input logic c, input logic rs);
    logic         m_full;
    logic         m_empty;
    logic         wa;
    logic         ra;
    logic [W-1:0] head;
    @(negedge clk);
    rst = rs; wen = w; din = d; ren = r; err_clr = c;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
      exp_valid = 1'b0;
      exp_dout  = '0;
    end else begin
      m_full  = (exp_q.size() == D);
      m_empty = (exp_q.size() == 0);
      wa = w && !m_full;
      ra = r && !m_empty;
      head = '0;
      if (ra) head = exp_q.pop_front();
      if (wa) exp_q.push_back(d);
      if (w && m_full)  exp_ovf = 1'b1;
      else if (c)       exp_ovf = 1'b0;
      if (r && m_empty) exp_unf = 1'b1;
      else if (c)       exp_unf = 1'b0;
      exp_valid = ra;
      if (ra) exp_dout = head;
    end
    #1;
    check_outputs();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [W-1:0] data;
    int           wr_pct;
    int           rd_pct;
    rst = 1'b1; wen = 1'b0; din = '0; ren = 1'b0; err_clr = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_valid = 1'b0; exp_dout = '0;

    // Reset for two cycles, then fill with 0..511.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    data = '0;
    for (int i = 0; i < D; i++) begin
      step(1'b1, data, 1'b0, 1'b0, 1'b0);
      data = data + 1'b1;
    end

    // Write while full, then clear the error.
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Drain and check the order.
    for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Read and write while empty: the read is rejected, the write is accepted.
    step(1'b1, 16'h00A5, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Write 300 words, run 1000 concurrent cycles across the wrap, then drain.
    data = 16'h1000;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, data, 1'b0, 1'b0, 1'b0);
      data = data + 1'b1;
    end
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, data, 1'b1, 1'b0, 1'b0);
      data = data + 1'b1;
    end
    for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset in mid-operation at count 37. The reset wins over wen and ren.
    for (int i = 0; i < 37; i++) begin
      step(1'b1, data, 1'b0, 1'b0, 1'b0);
      data = data + 1'b1;
    end
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic. The write/read bias changes every 250 cycles so the
    // FIFO reaches both full and empty.
    wr_pct = 50; rd_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        wr_pct = $urandom_range(95, 5);
        rd_pct = $urandom_range(95, 5);
      end
      step(($urandom_range(99, 0) < wr_pct), W'($urandom),
           ($urandom_range(99, 0) < rd_pct),
           ($urandom_range(15, 0) == 0),
           ($urandom_range(599, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
